uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 6 +
 rtl/uart_tx_arbiter_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 97 +++++++++
 tb/tb_uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and widths for the UART transmit arbiter
package uart_arb_pkg;
  localparam int GID_W = 3;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
endpackage

// File: rtl/uart_tx_arbiter_pick.sv
// rr_arbiter_pick: combinational round-robin pick, searching from ptr+1 upward with wrap
module rr_arbiter_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     eligible,
  input  logic [GID_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [GID_W-1:0] idx,
  output logic             any
);
  logic [GID_W-1:0] j;
  logic [N-1:0] sh;
  // walk from the farthest candidate down so the nearest eligible one wins
  always_comb begin
    idx = '0;
    j = '0;
    sh = '0;
    for (int i = N; i >= 1; i--) begin
      j = GID_W'((int'(ptr) + i) % N);
      sh = eligible >> j;
      idx = sh[0] ? j : idx;
    end
  end
  assign any = |eligible;
  assign grant = any ? N'(1) << idx : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among byte producers
// Packet locking (owner keeps the transmitter until its last byte) is enabled by UART_ARB_PKT_LOCK_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [BYTE_W-1:0]      o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy,
  output logic [GID_W-1:0]       o_grant_id,
  output logic                   o_grant_valid,
  output logic                   o_err
);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  state_t state;
  logic [GID_W-1:0] ptr, idx;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] eligible, grant;
  logic any, accept;
  logic [BYTE_W-1:0] win_data;
`ifdef UART_ARB_PKT_LOCK_EN
  logic lock;
  logic [NUM_REQ-1:0] last_sh;
  assign last_sh = i_req_last >> idx;
  assign eligible = lock ? i_req_valid & (NUM_REQ'(1) << o_grant_id) : i_req_valid;
`else
  logic unused_last;
  assign unused_last = ^i_req_last;
  assign eligible = i_req_valid;
`endif
  rr_arbiter_pick #(.N(NUM_REQ)) pick (
    .eligible(eligible),
    .ptr(ptr),
    .grant(grant),
    .idx(idx),
    .any(any)
  );
  assign accept = rst_n && state == IDLE && !i_tx_busy && any;
  assign o_req_ready = accept ? grant : '0;
  assign win_data = BYTE_W'(i_req_data >> {idx, 3'b000});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      o_tx_data <= '0;
      o_tx_start <= 1'b0;
      o_grant_id <= '0;
      o_grant_valid <= 1'b0;
      o_err <= 1'b0;
      ptr <= GID_W'(NUM_REQ - 1);
      cnt <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock <= 1'b0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      o_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          o_tx_data <= win_data;
          o_tx_start <= 1'b1;
          o_grant_id <= idx;
          o_grant_valid <= 1'b1;
          ptr <= idx;
          state <= SEND;
`ifdef UART_ARB_PKT_LOCK_EN
          lock <= !last_sh[0];
`endif
        end
        SEND: begin
          cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (i_tx_busy) state <= WAIT_DONE;
        else if (cnt == CW'(START_TIMEOUT - 1)) begin
          o_err <= 1'b1;
          o_grant_valid <= 1'b0;
          state <= IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
          lock <= 1'b0;
`endif
        end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (!i_tx_busy) begin
          o_grant_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors plus corner-case sequences against a transmitter busy model
module tb_uart_tx_arbiter;
  typedef struct {
    logic [3:0] valid;
    logic [2:0] gid;
    logic [7:0] data;
    int gap;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_last = '0, ready;
  logic [31:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_start, tx_busy = 1'b0, grant_valid, err;
  logic [2:0] grant_id;
  logic auto_busy = 1'b1, force_busy = 1'b0, q1_on = 1'b0, st_s = 1'b0;
  logic [3:0] rdy_s = '0, acc = '0;
  logic [7:0] q1d [4];
  logic [2:0] exp_g [5];
  logic [7:0] exp_d [5];
  vec_t v [10];
  int total = 0, passed = 0, cyc = 0, bc = 0, last_start = 0, n1 = 0, n_exp = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_req_valid(req_valid),
    .i_req_data(req_data),
    .i_req_last(req_last),
    .o_req_ready(ready),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .i_tx_busy(tx_busy),
    .o_grant_id(grant_id),
    .o_grant_valid(grant_valid),
    .o_err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic settle();
    #1;
    rdy_s = ready;
    acc = ready & req_valid;
  endtask

  // one clock: producer 1 pops on handshake, transmitter stays busy 10 cycles after each start
  task automatic step();
    @(negedge clk);
    cyc++;
    if (q1_on && acc[1]) n1++;
    if (q1_on) begin
      req_valid[1] = n1 < 3;
      req_data[15:8] = q1d[n1];
      req_last[1] = n1 == 2;
    end
    if (auto_busy && tx_start) bc = 10;
    else if (bc > 0) bc--;
    tx_busy = force_busy || bc > 0;
    settle();
    st_s = tx_start;
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 40; i++) begin
      step();
      if (st_s) return;
    end
    total++;
    $display("FAIL %s: no tx_start within 40 cycles", name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      step();
      if (!grant_valid && !tx_busy) return;
    end
    total++;
    $display("FAIL %s: grant still active after 60 cycles", name);
  endtask

  initial begin
    q1d[0] = 8'h11; q1d[1] = 8'h22; q1d[2] = 8'h33; q1d[3] = 8'h00;
    v[0] = '{4'b1111, 3'd0, 8'h11, 0};
    v[1] = '{4'b1111, 3'd1, 8'h22, 12};
    v[2] = '{4'b1111, 3'd2, 8'h33, 12};
    v[3] = '{4'b1111, 3'd3, 8'h44, 12};
    v[4] = '{4'b1111, 3'd0, 8'h11, 12};
    v[5] = '{4'b1010, 3'd1, 8'h22, 12};
    v[6] = '{4'b1001, 3'd3, 8'h44, 12};
    v[7] = '{4'b0110, 3'd1, 8'h22, 12};
    v[8] = '{4'b0100, 3'd2, 8'h33, 12};
    v[9] = '{4'b0011, 3'd0, 8'h11, 12};
`ifdef UART_ARB_PKT_LOCK_EN
    n_exp = 4;
    exp_g[0] = 3'd1; exp_g[1] = 3'd1; exp_g[2] = 3'd1; exp_g[3] = 3'd0; exp_g[4] = 3'd0;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'hF0; exp_d[4] = 8'h00;
`else
    n_exp = 5;
    exp_g[0] = 3'd1; exp_g[1] = 3'd0; exp_g[2] = 3'd1; exp_g[3] = 3'd0; exp_g[4] = 3'd1;
    exp_d[0] = 8'h11; exp_d[1] = 8'hF0; exp_d[2] = 8'h22; exp_d[3] = 8'hF0; exp_d[4] = 8'h33;
`endif
    req_last = 4'b1111;
    req_valid = 4'b1111;
    repeat (3) step();
    chk("rst_ready", ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_gvalid", grant_valid, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    req_data = 32'h44332211;
    // table: round-robin order and start spacing
    for (int i = 0; i < 10; i++) begin
      req_valid = v[i].valid;
      wait_start($sformatf("vec%0d_start", i));
      chk($sformatf("vec%0d_gid", i), grant_id, v[i].gid);
      chk($sformatf("vec%0d_data", i), tx_data, v[i].data);
      if (v[i].gap != 0) chk($sformatf("vec%0d_gap", i), cyc - last_start, v[i].gap);
      last_start = cyc;
    end
    req_valid = '0;
    wait_idle("vec_idle");
    // single requester, full frame
    req_data = 32'h00A50000;
    req_valid = 4'b0100;
    settle();
    chk("t1_ready", rdy_s, 4'b0100);
    step();
    chk("t1_start", st_s, 1);
    chk("t1_ready_once", rdy_s, 0);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_gid", grant_id, 2);
    chk("t1_gvalid", grant_valid, 1);
    req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!tx_busy) break;
    end
    chk("t1_gv_hold", grant_valid, 1);
    step();
    chk("t1_gv_drop", grant_valid, 0);
    // busy transmitter blocks the grant
    force_busy = 1'b1;
    step();
    req_valid = 4'b0001;
    settle();
    chk("t4_ready_busy0", rdy_s, 0);
    step();
    chk("t4_ready_busy1", rdy_s, 0);
    step();
    chk("t4_ready_busy2", rdy_s, 0);
    force_busy = 1'b0;
    step();
    chk("t4_ready_now", rdy_s, 4'b0001);
    wait_start("t4_start");
    chk("t4_gid", grant_id, 0);
    req_valid = '0;
    wait_idle("t4_idle");
    // start timeout
    auto_busy = 1'b0;
    req_valid = 4'b1100;
    wait_start("t5_start");
    chk("t5_gid", grant_id, 2);
    repeat (4) step();
    chk("t5_err_early", err, 0);
    step();
    chk("t5_err", err, 1);
    chk("t5_gvalid", grant_valid, 0);
    step();
    chk("t5_err_pulse", err, 0);
    chk("t5_next_start", st_s, 1);
    chk("t5_next_gid", grant_id, 3);
    req_valid = '0;
    wait_idle("t5_idle");
    auto_busy = 1'b1;
    // asynchronous reset mid-frame
    req_valid = 4'b0001;
    wait_start("t6_start");
    req_valid = '0;
    repeat (3) step();
    chk("t6_gv_before", grant_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_gvalid", grant_valid, 0);
    chk("t6_rst_data", tx_data, 0);
    chk("t6_rst_gid", grant_id, 0);
    chk("t6_rst_start", tx_start, 0);
    chk("t6_rst_ready", ready, 0);
    req_valid = 4'b1001;
    repeat (2) step();
    #1 rst_n = 1'b1;
    step();
    chk("t6_wait_busy", rdy_s, 0);
    wait_start("t6_restart");
    chk("t6_gid", grant_id, 0);
    req_valid = '0;
    wait_idle("t6_idle");
    // packet stream from requester 1 against a greedy requester 0
    req_data = 32'h000011F0;
    req_last = 4'b1101;
    req_valid = 4'b0011;
    n1 = 0;
    q1_on = 1'b1;
    settle();
    for (int i = 0; i < n_exp; i++) begin
      wait_start($sformatf("t3_start%0d", i));
      chk($sformatf("t3_gid%0d", i), grant_id, exp_g[i]);
      chk($sformatf("t3_data%0d", i), tx_data, exp_d[i]);
    end
    q1_on = 1'b0;
    req_valid = '0;
    wait_idle("t3_idle");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
